// File: rtl/nap_seq_pkg.sv
// Shared types and constant tables for the nucleic-acid processor valve sequencer.
// Valve masks use 1 = open; the top drives ~mask onto the pressurised control lines.
package nap_seq_pkg;

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StSettle = 4'd1,
    StFill   = 4'd2,
    StMix    = 4'd3,
    StBead   = 4'd4,
    StTrap   = 4'd5,
    StWash   = 4'd6,
    StElute  = 4'd7,
    StDone   = 4'd8
  } state_e;

  localparam int unsigned NUM_VALVES = 11;

  // Bit positions inside the valve vector
  localparam int unsigned V_LYSIS      = 10;
  localparam int unsigned V_WASH       = 9;
  localparam int unsigned V_ELUTE      = 8;
  localparam int unsigned V_VERTICAL   = 7;
  localparam int unsigned V_HORIZ      = 6;
  localparam int unsigned V_LOOP_EXIT  = 5;
  localparam int unsigned V_BEAD_VTL   = 4;
  localparam int unsigned V_BEAD_TRAP  = 3;
  localparam int unsigned V_DEAD_END   = 2;
  localparam int unsigned V_COLLECTION = 1;
  localparam int unsigned V_WASTE      = 0;

  localparam logic [NUM_VALVES-1:0] MASK_FILL  = 11'b100_1000_0000;
  localparam logic [NUM_VALVES-1:0] MASK_MIX   = 11'b000_0100_0000;
  localparam logic [NUM_VALVES-1:0] MASK_BEAD  = 11'b000_0011_0000;
  localparam logic [NUM_VALVES-1:0] MASK_TRAP  = 11'b000_0000_1100;
  localparam logic [NUM_VALVES-1:0] MASK_WASH  = 11'b010_1000_1001;
  localparam logic [NUM_VALVES-1:0] MASK_ELUTE = 11'b001_1000_1010;

  localparam logic [2:0] PUMP_IDLE = 3'b111;
  // Entry 0 is the first phase after enable: 110 -> 011 -> 101
  localparam logic [2:0][2:0] PUMP_PAT = {3'b101, 3'b011, 3'b110};

  function automatic logic [NUM_VALVES-1:0] open_mask(input state_e s);
    case (s)
      StFill:  return MASK_FILL;
      StMix:   return MASK_MIX;
      StBead:  return MASK_BEAD;
      StTrap:  return MASK_TRAP;
      StWash:  return MASK_WASH;
      StElute: return MASK_ELUTE;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/nap_pump_phase_gen.sv
// Three-phase peristaltic pump driver; restarts at the first phase on each enable
// and flags the last cycle of every full round.
module nap_pump_phase_gen
  import nap_seq_pkg::*;
#(
  parameter int unsigned PUMP_PHASE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  output logic [2:0] o_pump,
  output logic       o_round_done
);

  localparam int unsigned PW = (PUMP_PHASE > 1) ? $clog2(PUMP_PHASE) : 1;

  logic          r_active;
  logic [1:0]    r_phase;
  logic [PW-1:0] r_cnt;
  logic [2:0]    r_pump;
  logic          w_phase_end;
  logic [1:0]    w_phase_nxt;

  assign w_phase_end  = (r_cnt == PW'(PUMP_PHASE - 1));
  assign w_phase_nxt  = (r_phase == 2'd2) ? 2'd0 : r_phase + 2'd1;
  assign o_round_done = r_active && (r_phase == 2'd2) && w_phase_end;
  assign o_pump       = r_pump;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_phase  <= 2'd0;
      r_cnt    <= '0;
      r_pump   <= PUMP_IDLE;
    end else if (!i_en) begin
      r_active <= 1'b0;
      r_phase  <= 2'd0;
      r_cnt    <= '0;
      r_pump   <= PUMP_IDLE;
    end else if (!r_active) begin
      r_active <= 1'b1;
      r_phase  <= 2'd0;
      r_cnt    <= '0;
      r_pump   <= PUMP_PAT[0];
    end else if (w_phase_end) begin
      r_phase  <= w_phase_nxt;
      r_cnt    <= '0;
      r_pump   <= PUMP_PAT[w_phase_nxt];
    end else begin
      r_cnt    <= r_cnt + PW'(1);
    end
  end

endmodule

// File: rtl/nap_valve_sequencer.sv
// Extraction protocol sequencer: fill, mix, bead load, trap, wash xN, elute, with an
// all-closed settle step between every pair of active steps. All outputs are registered.
module nap_valve_sequencer
  import nap_seq_pkg::*;
#(
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned FILL_CYCLES   = 64,
  parameter int unsigned MIX_ROUNDS    = 16,
  parameter int unsigned PUMP_PHASE    = 4,
  parameter int unsigned DWELL_CYCLES  = 128,
  parameter int unsigned WASH_REPEATS  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic       i_abort,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_aborted,
  output logic [3:0] o_step,
  output logic       o_lysis_ctl,
  output logic       o_wash_ctl,
  output logic       o_elute_ctl,
  output logic       o_vertical_ctl,
  output logic       o_horiz_ctl,
  output logic       o_loop_exit_ctl,
  output logic       o_bead_vtl_ctl,
  output logic       o_bead_trap_ctl,
  output logic       o_dead_end_ctl,
  output logic       o_collection_ctl,
  output logic       o_waste_ctl,
  output logic       o_pump1,
  output logic       o_pump2,
  output logic       o_pump3
);

  state_e                r_state, w_state_d, r_next, w_next_d;
  logic [CNT_W-1:0]      r_cnt, w_cnt_d, r_wash, w_wash_d;
  logic [NUM_VALVES-1:0] r_valve;
  logic                  r_busy, r_done, r_aborted;
  logic                  w_last, w_round_done;
  logic [2:0]            w_pump;

  // In MIX the counter tracks completed pump rounds rather than cycles
  always_comb begin
    w_last = 1'b0;
    case (r_state)
      StSettle: w_last = (r_cnt == CNT_W'(SETTLE_CYCLES - 1));
      StFill:   w_last = (r_cnt == CNT_W'(FILL_CYCLES - 1));
      StMix:    w_last = w_round_done && (r_cnt == CNT_W'(MIX_ROUNDS - 1));
      StBead, StTrap, StWash, StElute: w_last = (r_cnt == CNT_W'(DWELL_CYCLES - 1));
      default:  w_last = 1'b0;
    endcase
  end

  always_comb begin
    w_state_d = r_state;
    w_next_d  = r_next;
    w_wash_d  = r_wash;
    if (r_state != StIdle && i_abort) begin
      w_state_d = StIdle;
    end else begin
      case (r_state)
        StIdle: if (i_start && !i_abort) begin
          w_state_d = StSettle;
          w_next_d  = StFill;
        end
        StSettle: if (w_last) w_state_d = r_next;
        StFill:   if (w_last) begin w_state_d = StSettle; w_next_d = StMix;  end
        StMix:    if (w_last) begin w_state_d = StSettle; w_next_d = StBead; end
        StBead:   if (w_last) begin w_state_d = StSettle; w_next_d = StTrap; end
        StTrap: if (w_last) begin
          w_state_d = StSettle;
          w_next_d  = StWash;
          w_wash_d  = '0;
        end
        StWash: if (w_last) begin
          w_state_d = StSettle;
          if (r_wash == CNT_W'(WASH_REPEATS - 1)) begin
            w_next_d = StElute;
          end else begin
            w_next_d = StWash;
            w_wash_d = r_wash + CNT_W'(1);
          end
        end
        StElute:  if (w_last) begin w_state_d = StSettle; w_next_d = StDone; end
        StDone:   w_state_d = StIdle;
        default:  w_state_d = StIdle;
      endcase
    end

    if (w_state_d != r_state)                   w_cnt_d = '0;
    else if (r_state == StMix)                  w_cnt_d = r_cnt + CNT_W'(w_round_done);
    else if (r_state == StIdle || r_state == StDone) w_cnt_d = r_cnt;
    else                                        w_cnt_d = r_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_next    <= StIdle;
      r_cnt     <= '0;
      r_wash    <= '0;
      r_valve   <= '1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_next    <= w_next_d;
      r_cnt     <= w_cnt_d;
      r_wash    <= w_wash_d;
      r_valve   <= ~open_mask(w_state_d);
      r_busy    <= (w_state_d != StIdle) && (w_state_d != StDone);
      r_done    <= (w_state_d == StDone);
      r_aborted <= (r_state != StIdle) && i_abort;
    end
  end

  nap_pump_phase_gen #(
    .PUMP_PHASE (PUMP_PHASE)
  ) u_pump (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_en         (w_state_d == StMix),
    .o_pump       (w_pump),
    .o_round_done (w_round_done)
  );

  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_aborted        = r_aborted;
  assign o_step           = r_state;
  assign o_lysis_ctl      = r_valve[V_LYSIS];
  assign o_wash_ctl       = r_valve[V_WASH];
  assign o_elute_ctl      = r_valve[V_ELUTE];
  assign o_vertical_ctl   = r_valve[V_VERTICAL];
  assign o_horiz_ctl      = r_valve[V_HORIZ];
  assign o_loop_exit_ctl  = r_valve[V_LOOP_EXIT];
  assign o_bead_vtl_ctl   = r_valve[V_BEAD_VTL];
  assign o_bead_trap_ctl  = r_valve[V_BEAD_TRAP];
  assign o_dead_end_ctl   = r_valve[V_DEAD_END];
  assign o_collection_ctl = r_valve[V_COLLECTION];
  assign o_waste_ctl      = r_valve[V_WASTE];
  assign {o_pump1, o_pump2, o_pump3} = w_pump;

endmodule

// File: tb/tb_nap_valve_sequencer.sv
// Directed bench for nap_valve_sequencer using the reduced-length protocol parameters.
module tb_nap_valve_sequencer;

  localparam logic [3:0] S_IDLE = 4'd0, S_SET = 4'd1, S_FILL = 4'd2, S_MIX = 4'd3;
  localparam logic [3:0] S_BEAD = 4'd4, S_TRAP = 4'd5, S_WASH = 4'd6, S_ELUTE = 4'd7;
  localparam logic [3:0] S_DONE = 4'd8;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic busy, done, aborted;
  logic [3:0] step;
  logic lysis, wash, elute, vertical, horiz, loop_exit, bead_vtl, bead_trap, dead_end;
  logic collection, waste, pump1, pump2, pump3;
  logic [10:0] ctl;
  logic [2:0] pumps;

  int n_vec = 0;
  int n_err = 0;
  logic [3:0] exp_seq[$];
  logic [2:0] pat_tbl[3];

  assign ctl   = {lysis, wash, elute, vertical, horiz, loop_exit, bead_vtl, bead_trap,
                  dead_end, collection, waste};
  assign pumps = {pump1, pump2, pump3};

  always #5 clk = ~clk;

  nap_valve_sequencer #(
    .CNT_W(16), .SETTLE_CYCLES(1), .FILL_CYCLES(4), .MIX_ROUNDS(2), .PUMP_PHASE(1),
    .DWELL_CYCLES(3), .WASH_REPEATS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_abort(abort),
    .o_busy(busy), .o_done(done), .o_aborted(aborted), .o_step(step),
    .o_lysis_ctl(lysis), .o_wash_ctl(wash), .o_elute_ctl(elute), .o_vertical_ctl(vertical),
    .o_horiz_ctl(horiz), .o_loop_exit_ctl(loop_exit), .o_bead_vtl_ctl(bead_vtl),
    .o_bead_trap_ctl(bead_trap), .o_dead_end_ctl(dead_end), .o_collection_ctl(collection),
    .o_waste_ctl(waste), .o_pump1(pump1), .o_pump2(pump2), .o_pump3(pump3)
  );

  // Open valves per step, order: lysis wash elute vert horiz loopx beadv trap dead coll waste
  function automatic logic [10:0] exp_open(input logic [3:0] s);
    case (s)
      S_FILL:  return 11'b10010000000;
      S_MIX:   return 11'b00001000000;
      S_BEAD:  return 11'b00000110000;
      S_TRAP:  return 11'b00000001100;
      S_WASH:  return 11'b01010001001;
      S_ELUTE: return 11'b00110001010;
      default: return 11'b00000000000;
    endcase
  endfunction

  function automatic void push_n(input logic [3:0] s, input int n);
    for (int i = 0; i < n; i++) exp_seq.push_back(s);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_vec++;
    if ({step, busy, done, aborted, ctl, pumps} !== {S_IDLE, 3'b000, 11'h7ff, 3'b111}) begin
      n_err++;
      $display("FAIL reset_init: got step=%0d busy=%b ctl=%b pumps=%b, need idle/0/all1/111",
               step, busy, ctl, pumps);
    end
    #3 rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 2; k <= 9; k++) tick();
    n_vec++;
    if ({step, pumps} !== {S_MIX, 3'b101}) begin
      n_err++;
      $display("FAIL reset_premix: got step=%0d pumps=%b, need 3/101", step, pumps);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({step, busy, done, aborted, ctl, pumps} !== {S_IDLE, 3'b000, 11'h7ff, 3'b111}) begin
      n_err++;
      $display("FAIL reset_async: got step=%0d busy=%b ctl=%b pumps=%b, need idle/0/all1/111",
               step, busy, ctl, pumps);
    end
    #3 rst_n = 1'b1;
    tick();
    n_vec++;
    if ({step, busy, done, aborted} !== {S_IDLE, 3'b000}) begin
      n_err++;
      $display("FAIL reset_after: got step=%0d busy=%b done=%b aborted=%b, need idle/0/0/0",
               step, busy, done, aborted);
    end
  endtask

  task automatic test_full_run();
    logic [3:0]  es;
    logic [2:0]  ep;
    int          mix_idx;
    int          busy_cnt;
    int          done_at;
    mix_idx  = 0;
    busy_cnt = 0;
    done_at  = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 34; k++) begin
      if (k > 1) tick();
      es = exp_seq[k-1];
      if (es == S_MIX) begin
        ep = pat_tbl[mix_idx % 3];
        mix_idx++;
      end else begin
        ep = 3'b111;
      end
      if (busy) busy_cnt++;
      if (done && done_at == 0) done_at = k;
      n_vec++;
      if ({step, ctl, pumps, busy, done, aborted} !==
          {es, ~exp_open(es), ep, (es != S_DONE), (es == S_DONE), 1'b0}) begin
        n_err++;
        $display("FAIL run_cycle%0d: got step=%0d ctl=%b pumps=%b busy=%b done=%b ab=%b, need step=%0d ctl=%b pumps=%b",
                 k, step, ctl, pumps, busy, done, aborted, es, ~exp_open(es), ep);
      end
    end
    n_vec++;
    if (busy_cnt != 33 || done_at != 34) begin
      n_err++;
      $display("FAIL run_length: got busy=%0d done_at=%0d, need 33/34", busy_cnt, done_at);
    end
    tick();
    n_vec++;
    if ({step, ctl, pumps, busy, done} !== {S_IDLE, 11'h7ff, 3'b111, 2'b00}) begin
      n_err++;
      $display("FAIL run_idle: got step=%0d ctl=%b pumps=%b busy=%b done=%b, need idle closed",
               step, ctl, pumps, busy, done);
    end
  endtask

  task automatic test_priority();
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    n_vec++;
    if ({step, busy, aborted} !== {S_IDLE, 2'b00}) begin
      n_err++;
      $display("FAIL start_abort_idle: got step=%0d busy=%b aborted=%b, need 0/0/0",
               step, busy, aborted);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_vec++;
    if ({step, aborted} !== {S_IDLE, 1'b0}) begin
      n_err++;
      $display("FAIL abort_idle: got step=%0d aborted=%b, need 0/0", step, aborted);
    end
  endtask

  task automatic test_back_to_back();
    int busy_cnt;
    int done_at;
    int done_cnt;
    busy_cnt = 0;
    done_at  = 0;
    done_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (k > 1) tick();
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (done && done_at == 0) done_at = k;
      start = (k == 5 || k == 6 || k == 20 || k == 30);
    end
    start = 1'b0;
    n_vec++;
    if (busy_cnt != 33 || done_at != 34 || done_cnt != 1) begin
      n_err++;
      $display("FAIL start_while_busy: got busy=%0d done_at=%0d dones=%0d, need 33/34/1",
               busy_cnt, done_at, done_cnt);
    end
  endtask

  task automatic test_abort();
    int done_cnt;
    int done_at;
    done_cnt = 0;
    done_at  = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 2; k <= 26; k++) tick();
    n_vec++;
    if (step !== S_WASH) begin
      n_err++;
      $display("FAIL abort_pre: got step=%0d, need %0d", step, S_WASH);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_vec++;
    if ({step, busy, done, aborted, ctl, pumps} !== {S_IDLE, 3'b001, 11'h7ff, 3'b111}) begin
      n_err++;
      $display("FAIL abort_edge: got step=%0d busy=%b done=%b ab=%b ctl=%b, need idle/0/0/1/closed",
               step, busy, done, aborted, ctl);
    end
    tick();
    n_vec++;
    if (aborted !== 1'b0) begin
      n_err++;
      $display("FAIL abort_pulse_len: got aborted=%b, need 0", aborted);
    end
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done) done_cnt++;
    end
    n_vec++;
    if (done_cnt != 0) begin
      n_err++;
      $display("FAIL abort_no_done: got %0d done pulses, need 0", done_cnt);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 40 && done_at == 0; k++) begin
      if (k > 1) tick();
      if (done) done_at = k;
    end
    n_vec++;
    if (done_at != 34) begin
      n_err++;
      $display("FAIL abort_rerun: got done at edge %0d, need 34", done_at);
    end
  endtask

  initial begin
    pat_tbl[0] = 3'b110;
    pat_tbl[1] = 3'b011;
    pat_tbl[2] = 3'b101;
    push_n(S_SET, 1); push_n(S_FILL, 4);
    push_n(S_SET, 1); push_n(S_MIX, 6);
    push_n(S_SET, 1); push_n(S_BEAD, 3);
    push_n(S_SET, 1); push_n(S_TRAP, 3);
    for (int w = 0; w < 2; w++) begin
      push_n(S_SET, 1); push_n(S_WASH, 3);
    end
    push_n(S_SET, 1); push_n(S_ELUTE, 3);
    push_n(S_SET, 1); push_n(S_DONE, 1);
    #9;
    test_reset();
    test_full_run();
    test_priority();
    test_back_to_back();
    tick();
    test_abort();
    tick();
    test_full_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench still running at 100000, need completion");
    $fatal(1);
  end

endmodule
